exception_ctrl: RTL
===================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter PC_W SHALL default to 16 and sets the program-counter width.
REQ-003 Parameter FLUSH_CYCLES SHALL default to 2 and sets the number of flush cycles; legal range is 1..15.
REQ-004 Parameter CNT_W SHALL default to 8 and sets the exception-counter width.
REQ-005 Port clk SHALL be an input, 1 bit: system clock.
REQ-006 Port rst_n SHALL be an input, 1 bit: synchronous active-low reset.
REQ-007 Port instr_valid SHALL be an input, 1 bit: opcode, overflow and pc are valid this cycle.
REQ-008 Port opcode SHALL be an input, 4 bits: opcode of the executing instruction.
REQ-009 Port overflow SHALL be an input, 1 bit: ALU overflow for that instruction.
REQ-010 Port pc SHALL be an input, PC_W bits: address of that instruction.
REQ-011 Port resume_req SHALL be an input, 1 bit: debugger/host request to leave the halt.
REQ-012 Port resume_ack SHALL be an output, 1 bit: one-cycle acknowledge of a resume.
REQ-013 Port stall SHALL be an output, 1 bit: freeze fetch/decode.
REQ-014 Port flush SHALL be an output, 1 bit: squash in-flight instructions.
REQ-015 Port halt SHALL be an output, 1 bit: core halted.
REQ-016 Port epc SHALL be an output, PC_W bits: pc of the faulting instruction.
REQ-017 Port cause SHALL be an output, 2 bits: 00 none, 01 illegal opcode, 10 overflow.
REQ-018 Port exc_count SHALL be an output, CNT_W bits: number of exceptions taken, saturating.

Function
REQ-019 Legal opcodes SHALL be 0x0, 0x4, 0x5, 0x6, 0x8, 0xB, 0xC and 0xF; every other opcode is illegal.
REQ-020 The FSM SHALL have four states: RUN, FLUSH, HALTED and RECOVER.
REQ-021 In RUN, an exception is detected when instr_valid=1 and (overflow=1 or the opcode is illegal); inputs with instr_valid=0 SHALL be ignored.
REQ-022 When overflow and an illegal opcode occur in the same cycle, overflow SHALL win and cause=10.
REQ-023 On a detected exception at edge N: epc<=pc, cause<=code, exc_count increments, state<=FLUSH, and the flush counter loads FLUSH_CYCLES-1.
REQ-024 exc_count SHALL saturate at all-ones and never wrap.
REQ-025 In FLUSH: flush=1 and stall=1; the counter decrements each cycle; at 0 the next state SHALL be HALTED, so flush is high for exactly FLUSH_CYCLES cycles.
REQ-026 In HALTED: halt=1 and stall=1, and the block stays there until resume_req=1, then goes to RECOVER.
REQ-027 In RECOVER: resume_ack=1 and stall=1 for exactly one cycle; cause<=00; epc is retained; the next state SHALL be RUN.
REQ-028 Outputs flush, stall, halt and resume_ack SHALL be a Moore decode of the state register, giving flush on cycle N+1 for an exception sampled at edge N.
REQ-029 In RUN, stall, flush, halt and resume_ack SHALL all be 0.
REQ-030 Exceptions arriving in FLUSH, HALTED or RECOVER SHALL be ignored: not captured and not counted.
REQ-031 resume_req outside HALTED SHALL be ignored and not queued.
REQ-032 With FLUSH_CYCLES=1, flush SHALL be high for exactly one cycle.

Reset
REQ-033 On a clk edge with rst_n=0, from any state including mid-flush or halted: state<=RUN, epc<=0, cause<=00, exc_count<=0, flush counter<=0.
REQ-034 During and after reset, stall, flush, halt and resume_ack SHALL be 0.

Structure
REQ-035 Package exc_pkg SHALL hold the state enum, the cause codes, the legal-opcode constants and an is_legal_opcode function.
REQ-036 One sub-module, exc_sat_counter (CNT_W-bit saturating incrementer with clear), SHALL implement exc_count; everything else is flat.

Verification
REQ-037 opcode=0x4, instr_valid=1, overflow=0 → no exception; all outputs 0; exc_count=0.
REQ-038 opcode=0x3, pc=0x0120 → flush for 2 cycles, then halt=1, epc=0x0120, cause=01, exc_count=1.
REQ-039 opcode=0x7 with overflow=1 in the same cycle, pc=0x0044 → cause=10, epc=0x0044.
REQ-040 While HALTED, inject opcode=0x9; then resume_req=1 → exc_count unchanged, resume_ack for 1 cycle, cause=00, back to RUN.
REQ-041 rst_n=0 during the 2nd flush cycle → next cycle RUN, flush=0, exc_count=0, epc=0.
REQ-042 CNT_W=2, 4 exceptions each resumed → exc_count stays at 3.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and helpers for the exception controller.
// State encoding, cause codes and the legal-opcode table.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_OVF     = 2'b10
  } cause_e;

  localparam logic [3:0] LEGAL_OP_0 = 4'h0;
  localparam logic [3:0] LEGAL_OP_4 = 4'h4;
  localparam logic [3:0] LEGAL_OP_5 = 4'h5;
  localparam logic [3:0] LEGAL_OP_6 = 4'h6;
  localparam logic [3:0] LEGAL_OP_8 = 4'h8;
  localparam logic [3:0] LEGAL_OP_B = 4'hB;
  localparam logic [3:0] LEGAL_OP_C = 4'hC;
  localparam logic [3:0] LEGAL_OP_F = 4'hF;

  function automatic logic is_legal_opcode(
    input logic [3:0] op
  );
    logic ok;
    ok = 1'b0;
    case (op)
      LEGAL_OP_0, LEGAL_OP_4,
      LEGAL_OP_5, LEGAL_OP_6,
      LEGAL_OP_8, LEGAL_OP_B,
      LEGAL_OP_C, LEGAL_OP_F: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/exc_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module exc_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: clear wins, increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: catch illegal opcode/overflow,
// flush the pipe, halt, and recover on host resume.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [3:0]       opcode,
  input  logic             overflow,
  input  logic [PC_W-1:0]  pc,
  input  logic             resume_req,
  output logic             resume_ack,
  output logic             stall,
  output logic             flush,
  output logic             halt,
  output logic [PC_W-1:0]  epc,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [3:0] FLUSH_LOAD =
    4'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [PC_W-1:0] epc_q, epc_d;
  cause_e          cause_q, cause_d;
  logic            exc_take;

  // state transitions and exception capture
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    exc_take = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (instr_valid &&
            (overflow || !is_legal_opcode(opcode))) begin
          exc_take = 1'b1;
          epc_d    = pc;
          cause_d  = overflow ? CAUSE_OVF
                              : CAUSE_ILLEGAL;
          fcnt_d   = FLUSH_LOAD;
          state_d  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == 4'd0) begin
          state_d = ST_HALTED;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      ST_HALTED: begin
        if (resume_req) begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        cause_d = CAUSE_NONE;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // state and capture registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= 4'd0;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  exc_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .clr   (!rst_n),
    .inc   (exc_take),
    .count (exc_count)
  );

  assign flush      = (state_q == ST_FLUSH);
  assign halt       = (state_q == ST_HALTED);
  assign resume_ack = (state_q == ST_RECOVER);
  assign stall      = (state_q != ST_RUN);
  assign epc        = epc_q;
  assign cause      = cause_q;

endmodule
